// File: rtl/hdmi_tmds_decode.sv
// TMDS decoder for three word-aligned channels: control/data classification, 2-stage pipeline,
// sync recovery from blue and control-period framing lock with error tracking.
module hdmi_tmds_decode #(
   parameter int unsigned CTL_MIN      = 8,
   parameter int unsigned LOCK_PERIODS = 4,
   parameter int unsigned ERR_LIMIT    = 4
) (
   input  logic        i_pix_clk,
   input  logic        i_reset,
   input  logic [9:0]  i_r,
   input  logic [9:0]  i_g,
   input  logic [9:0]  i_b,
   output logic [7:0]  o_r,
   output logic [7:0]  o_g,
   output logic [7:0]  o_b,
   output logic        o_de,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_locked,
   output logic [15:0] o_err_count
);

   localparam int unsigned RunW  = $clog2(CTL_MIN + 1);
   localparam int unsigned QualW = $clog2(LOCK_PERIODS + 1);
   localparam int unsigned ErrW  = $clog2(ERR_LIMIT + 1);

   typedef enum logic [0:0] {StSearch, StLocked} state_e;

   // {is_control, c1, c0}
   function automatic logic [2:0] ctl_token(input logic [9:0] s);
      logic [2:0] t;
      case (s)
         10'h354: t = 3'b100;
         10'h0AB: t = 3'b101;
         10'h154: t = 3'b110;
         10'h2AB: t = 3'b111;
         default: t = 3'b000;
      endcase
      return t;
   endfunction

   function automatic logic [7:0] data_byte(input logic [9:0] s);
      logic [7:0] d;
      logic [7:0] q;
      d    = s[9] ? ~s[7:0] : s[7:0];
      q    = '0;
      q[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      return q;
   endfunction

   logic [2:0]       tok_r, tok_g, tok_b;
   logic [7:0]       r_byte_q, g_byte_q, b_byte_q;
   logic [2:0]       ctl_q;
   logic [1:0]       b_c_q;
   logic [RunW-1:0]  run_q, run_d;
   logic [QualW-1:0] qual_q, qual_d;
   logic [ErrW-1:0]  err_run_q, err_run_d;
   state_e           state_q, state_d;
   logic             all_ctl, all_data, disagree, qualify, de_d;

   always_comb begin
      tok_r = ctl_token(i_r);
      tok_g = ctl_token(i_g);
      tok_b = ctl_token(i_b);
   end

   // Stage 1: per-channel decode and control classification.
   always_ff @(posedge i_pix_clk or posedge i_reset) begin
      if (i_reset) begin
         r_byte_q <= '0;
         g_byte_q <= '0;
         b_byte_q <= '0;
         ctl_q    <= '0;
         b_c_q    <= '0;
      end else begin
         r_byte_q <= data_byte(i_r);
         g_byte_q <= data_byte(i_g);
         b_byte_q <= data_byte(i_b);
         ctl_q    <= {tok_r[2], tok_g[2], tok_b[2]};
         b_c_q    <= tok_b[1:0];
      end
   end

   always_comb begin
      all_ctl  = &ctl_q;
      all_data = ~|ctl_q;
      disagree = ~all_ctl & ~all_data;
      qualify  = all_data && (run_q == RunW'(CTL_MIN));
      run_d    = '0;
      if (all_ctl) begin
         run_d = (run_q == RunW'(CTL_MIN)) ? run_q : run_q + 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      qual_d    = qual_q;
      err_run_d = err_run_q;
      case (state_q)
         StSearch: begin
            if (disagree) begin
               qual_d = '0;
            end else if (qualify) begin
               if (qual_q == QualW'(LOCK_PERIODS - 1)) begin
                  state_d = StLocked;
                  qual_d  = '0;
               end else begin
                  qual_d = qual_q + 1'b1;
               end
            end
         end
         StLocked: begin
            if (disagree) begin
               if (err_run_q == ErrW'(ERR_LIMIT - 1)) begin
                  state_d   = StSearch;
                  err_run_d = '0;
                  qual_d    = '0;
               end else begin
                  err_run_d = err_run_q + 1'b1;
               end
            end else if (qualify) begin
               err_run_d = '0;
            end
         end
         default: state_d = StSearch;
      endcase
      // Lock is taken from the next state so o_locked lines up with the symbol that caused it.
      de_d = all_data && (state_d == StLocked);
   end

   // Stage 2: framing state and registered outputs.
   always_ff @(posedge i_pix_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= StSearch;
         run_q       <= '0;
         qual_q      <= '0;
         err_run_q   <= '0;
         o_r         <= '0;
         o_g         <= '0;
         o_b         <= '0;
         o_de        <= 1'b0;
         o_hsync     <= 1'b0;
         o_vsync     <= 1'b0;
         o_locked    <= 1'b0;
         o_err_count <= '0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         qual_q    <= qual_d;
         err_run_q <= err_run_d;
         o_r       <= de_d ? r_byte_q : 8'h00;
         o_g       <= de_d ? g_byte_q : 8'h00;
         o_b       <= de_d ? b_byte_q : 8'h00;
         o_de      <= de_d;
         o_locked  <= (state_d == StLocked);
         if (all_ctl) begin
            o_hsync <= b_c_q[0];
            o_vsync <= b_c_q[1];
         end
         if (disagree && (o_err_count != 16'hFFFF)) begin
            o_err_count <= o_err_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_hdmi_tmds_decode.sv
// Bench for hdmi_tmds_decode: behavioural framing model with a 2-deep expectation queue,
// decode vector table, directed lock/unlock/reset sequences and randomized lines.
module tb_hdmi_tmds_decode;

   localparam int CTL_MIN      = 8;
   localparam int LOCK_PERIODS = 4;
   localparam int ERR_LIMIT    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  i_r = '0, i_g = '0, i_b = '0;
   logic [7:0]  o_r, o_g, o_b;
   logic        o_de, o_hsync, o_vsync, o_locked;
   logic [15:0] o_err_count;

   hdmi_tmds_decode #(
      .CTL_MIN      (CTL_MIN),
      .LOCK_PERIODS (LOCK_PERIODS),
      .ERR_LIMIT    (ERR_LIMIT)
   ) dut (
      .i_pix_clk   (clk),
      .i_reset     (rst),
      .i_r         (i_r),
      .i_g         (i_g),
      .i_b         (i_b),
      .o_r         (o_r),
      .o_g         (o_g),
      .o_b         (o_b),
      .o_de        (o_de),
      .o_hsync     (o_hsync),
      .o_vsync     (o_vsync),
      .o_locked    (o_locked),
      .o_err_count (o_err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  r, g, b;
      logic        de, hs, vs, lk;
      logic [15:0] err;
   } out_t;

   typedef struct {
      logic [9:0] r, g, b;
      logic [7:0] er, eg, eb;
   } vec_t;

   int   n_checks = 0;
   int   n_errors = 0;
   out_t expq[$];

   // Model state: plain integers for the framing rules.
   int m_run, m_qual, m_erun, m_err;
   bit m_lock, m_hs, m_vs;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // {is_control, c1, c0}
   function automatic logic [2:0] tok(input logic [9:0] s);
      if (s == 10'h354) return 3'b100;
      if (s == 10'h0AB) return 3'b101;
      if (s == 10'h154) return 3'b110;
      if (s == 10'h2AB) return 3'b111;
      return 3'b000;
   endfunction

   function automatic logic [7:0] dec(input logic [9:0] s);
      logic [7:0] d;
      d = s[9] ? ~s[7:0] : s[7:0];
      return (d ^ {d[6:0], 1'b0}) ^ (s[8] ? 8'h00 : 8'hFE);
   endfunction

   function automatic logic [9:0] rnd_data();
      logic [9:0] s;
      s = 10'($urandom);
      if (tok(s)[2]) s = s ^ 10'h001;
      return s;
   endfunction

   function automatic void model_reset();
      m_run = 0; m_qual = 0; m_erun = 0; m_err = 0;
      m_lock = 0; m_hs = 0; m_vs = 0;
      expq.delete();
      expq.push_back('0);
   endfunction

   function automatic out_t model_step(input logic [9:0] r, input logic [9:0] g,
                                       input logic [9:0] b);
      out_t e;
      int   nctl;
      bit   q;
      logic [2:0] tb_tok;
      tb_tok = tok(b);
      nctl = int'(tok(r)[2]) + int'(tok(g)[2]) + int'(tb_tok[2]);
      if (nctl == 3) begin
         m_hs  = tb_tok[0];
         m_vs  = tb_tok[1];
         m_run = (m_run < CTL_MIN) ? m_run + 1 : CTL_MIN;
      end else if (nctl == 0) begin
         q     = (m_run == CTL_MIN);
         m_run = 0;
         if (q && !m_lock) begin
            m_qual++;
            if (m_qual == LOCK_PERIODS) begin
               m_lock = 1;
               m_qual = 0;
            end
         end else if (q) begin
            m_erun = 0;
         end
      end else begin
         m_run = 0;
         if (m_err < 65535) m_err++;
         if (!m_lock) begin
            m_qual = 0;
         end else begin
            m_erun++;
            if (m_erun == ERR_LIMIT) begin
               m_lock = 0;
               m_erun = 0;
               m_qual = 0;
            end
         end
      end
      e.de  = (nctl == 0) && m_lock;
      e.r   = e.de ? dec(r) : 8'h00;
      e.g   = e.de ? dec(g) : 8'h00;
      e.b   = e.de ? dec(b) : 8'h00;
      e.hs  = m_hs;
      e.vs  = m_vs;
      e.lk  = m_lock;
      e.err = 16'(m_err);
      return e;
   endfunction

   function automatic out_t actual();
      return {o_r, o_g, o_b, o_de, o_hsync, o_vsync, o_locked, o_err_count};
   endfunction

   // Applies one symbol set; afterwards the outputs show the previous symbol set.
   task automatic step(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
      out_t e;
      i_r = r; i_g = g; i_b = b;
      expq.push_back(model_step(r, g, b));
      @(posedge clk);
      #1;
      e = expq.pop_front();
      chk("cycle", 64'(actual()), 64'(e));
   endtask

   task automatic line(input int nctl, input logic [9:0] bctl, input int ndata);
      for (int i = 0; i < nctl; i++) step(10'h354, 10'h354, bctl);
      for (int i = 0; i < ndata; i++) step(rnd_data(), rnd_data(), rnd_data());
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   vec_t       tbl[4];
   logic [9:0] toks[4];

   initial begin
      tbl[0] = '{r: 10'h1FF, g: 10'h100, b: 10'h000, er: 8'h01, eg: 8'h00, eb: 8'hFE};
      tbl[1] = '{r: 10'h0FF, g: 10'h200, b: 10'h300, er: 8'hFF, eg: 8'hFF, eb: 8'h01};
      tbl[2] = '{r: 10'h155, g: 10'h1AA, b: 10'h0AA, er: 8'hFF, eg: 8'hFE, eb: 8'h00};
      tbl[3] = '{r: 10'h10F, g: 10'h1FF, b: 10'h155, er: 8'h11, eg: 8'h01, eb: 8'hFF};
      toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;

      // Reset state
      i_r = 10'h2AB; i_g = 10'h2AB; i_b = 10'h2AB;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 64'(actual()), 64'(0));
      release_reset();

      // Runs one short of CTL_MIN never qualify
      for (int k = 0; k < 6; k++) begin
         line(CTL_MIN - 1, 10'h354, 10);
         chk("short_run_no_lock", 64'(o_locked), 64'(0));
      end

      // Three full lines, then the fourth qualifying period by hand
      for (int k = 0; k < 3; k++) line(10, 10'h354, 20);
      chk("lock_before_4th", 64'(o_locked), 64'(0));
      line(10, 10'h354, 0);
      step(10'h100, 10'h100, 10'h100);
      chk("lock_not_yet", 64'(o_locked), 64'(0));
      step(10'h100, 10'h100, 10'h100);
      chk("lock_rise", 64'(o_locked), 64'(1));
      chk("de_with_lock", 64'(o_de), 64'(1));
      line(0, 10'h354, 18);
      chk("de_on_data", 64'(o_de), 64'(1));

      // Decode table, each entry followed by a filler so its output is visible
      for (int i = 0; i < 4; i++) begin
         step(tbl[i].r, tbl[i].g, tbl[i].b);
         step(10'h100, 10'h100, 10'h100);
         chk("tbl_de", 64'(o_de), 64'(1));
         chk("tbl_r", 64'(o_r), 64'(tbl[i].er));
         chk("tbl_g", 64'(o_g), 64'(tbl[i].eg));
         chk("tbl_b", 64'(o_b), 64'(tbl[i].eb));
      end

      // Blue 2AB control run sets both syncs and holds them over data
      chk("hsync_before", 64'(o_hsync), 64'(0));
      line(10, 10'h2AB, 20);
      chk("hsync_held", 64'(o_hsync), 64'(1));
      chk("vsync_held", 64'(o_vsync), 64'(1));

      // Four disagreement cycles drop lock
      for (int i = 0; i < 4; i++) step(10'h354, rnd_data(), rnd_data());
      step(10'h100, 10'h100, 10'h100);
      chk("unlock", 64'(o_locked), 64'(0));
      chk("err_count_4", 64'(o_err_count), 64'(4));
      line(10, 10'h354, 20);
      chk("de_after_unlock", 64'(o_de), 64'(0));

      // Relock, then asynchronous reset mid-data
      for (int k = 0; k < 3; k++) line(10, 10'h354, 20);
      chk("relock", 64'(o_locked), 64'(1));
      #2 rst = 1'b1;
      #1;
      chk("async_reset", 64'(actual()), 64'(0));
      repeat (2) @(posedge clk);
      release_reset();
      line(10, 10'h354, 20);
      chk("no_lock_after_reset", 64'(o_locked), 64'(0));
      for (int k = 0; k < 3; k++) line(10, 10'h354, 20);
      chk("lock_after_reset", 64'(o_locked), 64'(1));
      chk("err_after_reset", 64'(o_err_count), 64'(0));

      // Randomized lines with occasional disagreements
      for (int k = 0; k < 80; k++) begin
         int nc, nd;
         logic [9:0] bt;
         nc = int'($urandom_range(5, 11));
         nd = int'($urandom_range(3, 30));
         bt = toks[$urandom_range(0, 3)];
         for (int i = 0; i < nc; i++) begin
            if ($urandom_range(0, 31) == 0) step(10'h354, rnd_data(), bt);
            else step(10'h354, toks[$urandom_range(0, 3)], bt);
         end
         for (int i = 0; i < nd; i++) begin
            if ($urandom_range(0, 15) == 0) step(rnd_data(), toks[$urandom_range(0, 3)], rnd_data());
            else step(rnd_data(), rnd_data(), rnd_data());
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
